// File: rtl/alu_result_stage.sv
// Capture stage between the ALU and the 32-bit internal bus: a small result FIFO
// that emits narrow results as one beat and wide (MUL/DIV) results as low/high beats.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_result,
  input  logic                  in_wide,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_hi,
  output logic                  out_last,
  output logic                  out_zero,
  output logic                  out_neg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    BEAT_LO = 1'b0,
    BEAT_HI = 1'b1
  } beat_t;

  logic [2*DATA_W-1:0] res_q [DEPTH];
  logic [2*DATA_W-1:0] res_d [DEPTH];
  logic [DEPTH-1:0]    wide_q, wide_d;
  logic [DEPTH-1:0]    zero_q, zero_d;
  logic [DEPTH-1:0]    neg_q, neg_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  beat_t               beat_q, beat_d;

  logic [2*DATA_W-1:0] head_res;
  logic                head_wide;
  logic                head_zero;
  logic                head_neg;
  logic                cap_zero;
  logic                cap_neg;
  logic                push;
  logic                fire;
  logic                pop;

  assign head_res  = res_q[rd_ptr_q];
  assign head_wide = wide_q[rd_ptr_q];
  assign head_zero = zero_q[rd_ptr_q];
  assign head_neg  = neg_q[rd_ptr_q];

  // Flags are judged on the meaningful width of the result only.
  assign cap_zero = in_wide ? (in_result == '0) : (in_result[DATA_W-1:0] == '0);
  assign cap_neg  = in_wide ? in_result[2*DATA_W-1] : in_result[DATA_W-1];

  always_comb begin
    out_valid = (count_q != '0);
    in_ready  = (count_q != FULL);
    out_data  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    if (out_valid) begin
      out_zero = head_zero;
      out_neg  = head_neg;
      if (beat_q == BEAT_HI) begin
        out_data = head_res[2*DATA_W-1:DATA_W];
        out_hi   = 1'b1;
        out_last = 1'b1;
      end else begin
        out_data = head_res[DATA_W-1:0];
        out_last = !head_wide;
      end
    end
  end

  assign push = in_valid && in_ready;
  assign fire = out_valid && out_ready;
  assign pop  = fire && out_last;

  always_comb begin
    res_d    = res_q;
    wide_d   = wide_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;

    if (push) begin
      res_d[wr_ptr_q]  = in_result;
      wide_d[wr_ptr_q] = in_wide;
      zero_d[wr_ptr_q] = cap_zero;
      neg_d[wr_ptr_q]  = cap_neg;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A non-final beat can only be the low half of a wide head.
    if (fire) begin
      beat_d = pop ? BEAT_LO : BEAT_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= BEAT_LO;
      wide_q   <= '0;
      zero_q   <= '0;
      neg_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      wide_q   <= wide_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  // Result payload needs no reset; it is never observed while its entry is empty.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream capture stage between the ALU datapath and the internal bus.
- Accepts each ALU result, including the rotate/shift unit outputs and the 64-bit MUL/DIV results, into a small FIFO with valid/ready handshakes.
- Emits each result onto the 32-bit bus side as one beat for a narrow result, or two beats (low word, then high word) for a wide result.
- Computes zero and negative flags for each result as it is captured.

Parameters:
- DATA_W, 32: bus word width; in_result is 2*DATA_W bits wide.
- DEPTH, 2: number of FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  synchronous reset, active-high.
- in_valid  input  1  ALU result present.
- in_ready  output  1  stage can accept a result.
- in_result  input  2*DATA_W  ALU result; only [DATA_W-1:0] is meaningful when in_wide=0.
- in_wide  input  1  result is 64-bit (MUL/DIV); 0 for all 32-bit ops (ROL, ROR, ADD, ...).
- out_valid  output  1  beat available.
- out_ready  input  1  bus side accepts the current beat.
- out_data  output  DATA_W  current beat word.
- out_hi  output  1  1 when the current beat is the high word of a wide result.
- out_last  output  1  current beat is the final beat of its result.
- out_zero  output  1  entire result of the head entry is zero.
- out_neg  output  1  sign bit of the head entry result.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is synchronous and active-high. On clr:
  - count=0 and read/write pointers=0.
  - beat state=LO.
  - out_valid=0, in_ready=1.
  - out_data, out_hi, out_last, out_zero and out_neg all read 0.
- Storage: each entry holds result[2*DATA_W-1:0], wide, zero and neg.
  - zero: for a narrow result, result[DATA_W-1:0]==0; for a wide result, the full 2*DATA_W bits are 0.
  - neg: bit DATA_W-1 for a narrow result, bit 2*DATA_W-1 for a wide result.
  - Both flags are computed at capture time.
- Push: on a rising edge with in_valid && in_ready, write the entry at the write pointer; the pointer increments and wraps modulo DEPTH.
- in_ready: equals (count != DEPTH), driven from registered count only.
  - No same-cycle pass-through: when full, in_ready=0 even if a pop occurs that cycle.
- Output validity: out_valid = (count != 0). All out_* signals come combinationally from the head entry and the beat state. When empty, all out_* read 0.
- Beat state machine (2 states):
  - LO: out_data = head[DATA_W-1:0]; out_hi=0; out_last = !head.wide.
  - HI: out_data = head[2*DATA_W-1:DATA_W]; out_hi=1; out_last=1.
  - On out_valid && out_ready in LO with a wide head: go to HI, no pop.
  - On out_valid && out_ready with out_last=1: pop (read pointer increments and wraps) and go to LO.
  - The HI state is reachable only for a wide head.
- Latency: a result pushed at edge N is visible on out_* after edge N (first-word latency 1 cycle). Throughput is one beat per cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Stability: out_* are held stable while out_valid && !out_ready. In-flight data is never reordered or dropped.
- Reset mid-operation: clr discards all entries, including a wide result whose low beat was already sent; the beat state returns to LO.
- in_valid while in_ready=0: ignored, no state change. The upstream side must hold its data.

Test Plan:
1. Reset then idle: assert clr for 2 cycles → out_valid=0, in_ready=1, out_data=0, out_zero=0.
2. Narrow push of in_result=0x00000000_80000001, in_wide=0, out_ready=1 → next cycle one beat: out_data=0x80000001, out_hi=0, out_last=1, out_neg=1, out_zero=0; the following cycle out_valid=0.
3. Wide push of 0x00000001_00000000 with out_ready=1 → beat 1: out_data=0x00000000, out_hi=0, out_last=0. Beat 2: out_data=0x00000001, out_hi=1, out_last=1. out_zero=0 and out_neg=0 on both beats.
4. Backpressure: out_ready=0, push 3 narrow results (0x11, 0x22, 0x33) → the first two are accepted and in_ready=0 after the second. Raise out_ready while holding the third → order 0x11, 0x22, then 0x33 accepted and delivered with no loss.
5. Simultaneous push/pop at count=1 with a narrow head and out_ready=1 → count stays 1, the new word appears on the next cycle, and in_ready stays 1 throughout.
6. Reset mid-wide: push wide 0xAAAAAAAA_55555555, accept the low beat (0x55555555), pulse clr → out_valid=0 next cycle, the high beat is never emitted, and a subsequent narrow push of 0x7 emits out_data=0x7, out_hi=0.
